// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: widths, the NOP
// encoding presented while the queue is empty, and the stored entry layout.
package fetch_queue_pkg;

  localparam int FQ_DEPTH = 4;   // default number of queue entries (power of 2, >= 2)
  localparam int PC_W     = 8;   // fetch PC / instruction-memory address width
  localparam int INSTR_W  = 9;   // instruction width

  // Presented on out_instr whenever the queue has no valid head entry.
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  // One buffered fetch: the address it came from and the word read there.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } FetchEntry;

  // Builds a queue entry from the current fetch PC and memory read data.
  function automatic FetchEntry make_entry(input logic [PC_W-1:0] pc,
                                           input logic [INSTR_W-1:0] instr);
    FetchEntry e;
    e.pc    = pc;
    e.instr = instr;
    return e;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the fetch-queue signals: instruction-memory port, decode-side
// control (stall / flush / redirect) and the head-of-queue outputs.
// The master side is the queue itself (it owns the fetch PC and drives the
// memory address); the slave side is the surrounding pipeline / memory.
interface fetch_queue_if #(
  parameter int DEPTH = fetch_queue_pkg::FQ_DEPTH
);
  import fetch_queue_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               stall;
  logic               flush;
  logic [PC_W-1:0]    redirect_pc;
  logic               out_valid;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic [CNT_W-1:0]   count;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  stall,
    input  flush,
    input  redirect_pc,
    output out_valid,
    output out_pc,
    output out_instr,
    output count
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output stall,
    output flush,
    output redirect_pc,
    input  out_valid,
    input  out_pc,
    input  out_instr,
    input  count
  );

endinterface

// File: rtl/fetch_queue_ram.sv
// DEPTH x FetchEntry storage for the prefetch queue. One synchronous write
// port, one asynchronous read port. Contents are not reset: the queue only
// ever reads slots it has written since the last reset or flush.
module fetch_queue_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  FetchEntry                i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output FetchEntry                o_rdata
);

  FetchEntry r_mem [DEPTH];

  // Write the addressed slot on enable; no reset on the storage array.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Asynchronous read so the head entry is visible in the same cycle the
  // head pointer points at it (outputs still depend on registered state only).
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between instruction memory and the IF/ID stage.
// Owns the fetch PC, buffers up to DEPTH {pc, instr} entries while decode is
// stalled, and on a taken branch discards everything and refetches from the
// redirect target. There is no empty-queue bypass: an entry written at an
// edge becomes visible at the outputs only after that edge.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic          clk,
  input  logic          reset,   // asynchronous, active-low
  fetch_queue_if.master fq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [PC_W-1:0]  r_fetch_pc;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic      w_out_valid;
  logic      w_pop;
  logic      w_push;
  logic      w_we;
  FetchEntry w_wdata;
  FetchEntry w_rdata;

  // Head is valid whenever anything is buffered. Pop only when decode accepts.
  // A full queue can still push on a pop cycle: the slot freed at the head is
  // the very slot the tail points at, and the read happens before the write.
  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid & ~fq.stall;
  assign w_push      = (r_count < FULL_COUNT) | w_pop;

  // A flush cycle discards the memory word fetched from the old path.
  assign w_we    = w_push & ~fq.flush;
  assign w_wdata = make_entry(r_fetch_pc, fq.imem_instr);

  fetch_queue_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_tail),
    .i_wdata (w_wdata),
    .i_raddr (r_head),
    .o_rdata (w_rdata)
  );

  // Fetch PC, pointers and occupancy; flush restarts the queue at the target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (fq.flush) begin
      r_fetch_pc <= fq.redirect_pc;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      // Pointers and fetch PC wrap naturally at their widths.
      if (w_push) begin
        r_tail     <= r_tail + 1'b1;
        r_fetch_pc <= r_fetch_pc + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Head-of-queue outputs, masked to PC 0 / NOP while the queue is empty.
  always_comb begin
    fq.imem_addr = r_fetch_pc;
    fq.count     = r_count;
    fq.out_valid = w_out_valid;
    fq.out_pc    = '0;
    fq.out_instr = NOP_INSTR;
    if (w_out_valid) begin
      fq.out_pc    = w_rdata.pc;
      fq.out_instr = w_rdata.instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue. Instruction memory is modelled as
// imem[k] = k+1. A vector table drives stall/flush/redirect for one clock each
// and lists the outputs expected just after that edge; reset corners are
// written out as explicit sequences.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic clk;
  logic reset;

  fetch_queue_if fq_if ();

  fetch_queue dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq_if)
  );

  // Instruction memory: word at address k is k+1 (9 bits, so FF -> 0x100).
  assign fq_if.imem_instr = INSTR_W'(fq_if.imem_addr) + INSTR_W'(1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       stall;
    logic       flush;
    logic [7:0] redir;
    logic       valid;
    logic [7:0] pc;
    logic [8:0] instr;
    logic [2:0] count;
    logic [7:0] addr;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic s, input logic f, input logic [7:0] r,
                              input logic v, input logic [7:0] pc,
                              input logic [2:0] c, input logic [7:0] a);
    vec_t x;
    x.stall = s;
    x.flush = f;
    x.redir = r;
    x.valid = v;
    x.pc    = pc;
    x.instr = v ? (9'(pc) + 9'd1) : 9'h000;
    x.count = c;
    x.addr  = a;
    return x;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s [%0d] got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic v,
                           input logic [7:0] pc, input logic [8:0] ins,
                           input logic [2:0] c, input logic [7:0] a);
    check({tag, ".out_valid"}, idx, 32'(fq_if.out_valid), 32'(v));
    check({tag, ".out_pc"},    idx, 32'(fq_if.out_pc),    32'(pc));
    check({tag, ".out_instr"}, idx, 32'(fq_if.out_instr), 32'(ins));
    check({tag, ".count"},     idx, 32'(fq_if.count),     32'(c));
    check({tag, ".imem_addr"}, idx, 32'(fq_if.imem_addr), 32'(a));
    $display("%s %0d: valid=%0d pc=%h instr=%h count=%0d addr=%h", tag, idx,
             fq_if.out_valid, fq_if.out_pc, fq_if.out_instr, fq_if.count,
             fq_if.imem_addr);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Test 2: stall from reset fills to DEPTH, then drains in order.
    for (int i = 0; i < 6; i++) begin
      vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 3'(i < 4 ? i + 1 : 4), 8'(i < 4 ? i + 1 : 4)));
    end
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 8'(i + 1), 3'd4, 8'(i + 5)));
    end
    // Test 3: full at PCs 8..11, flush to 0x40 with stall held.
    vecs.push_back(mk(1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 3'd0, 8'h40));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 3'd1, 8'h41));
    // Test 4: fill, single-cycle release, then drain across the wrap.
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 3'd2, 8'h42));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 3'd3, 8'h43));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 3'd4, 8'h44));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 3'd4, 8'h44));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 8'h41, 3'd4, 8'h45));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h41, 3'd4, 8'h45));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 8'h42, 3'd4, 8'h46));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 8'h43, 3'd4, 8'h47));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 8'h44, 3'd4, 8'h48));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 8'h45, 3'd4, 8'h49));
    // Test 5: redirect to FE from a full queue, PC wraps FF -> 00.
    vecs.push_back(mk(1'b0, 1'b1, 8'hFE, 1'b0, 8'h00, 3'd0, 8'hFE));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 8'hFE, 3'd1, 8'hFF));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 3'd1, 8'h00));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 3'd1, 8'h01));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 3'd1, 8'h02));

    reset             = 1'b0;
    fq_if.stall       = 1'b0;
    fq_if.flush       = 1'b0;
    fq_if.redirect_pc = 8'h00;

    // Reset state, including a flush request held during reset.
    #3;
    check_all("reset", 0, 1'b0, 8'h00, NOP_INSTR, 3'd0, 8'h00);
    fq_if.flush       = 1'b1;
    fq_if.redirect_pc = 8'h33;
    step();
    check_all("reset", 1, 1'b0, 8'h00, NOP_INSTR, 3'd0, 8'h00);
    fq_if.flush = 1'b0;

    // Test 1: free-running fetch after release, one entry in flight.
    reset = 1'b1;
    #2;
    check_all("t1", 0, 1'b0, 8'h00, NOP_INSTR, 3'd0, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      step();
      check_all("t1", k, 1'b1, 8'(k - 1), 9'(k), 3'd1, 8'(k));
    end

    // Re-enter reset with stall already asserted for the table run.
    reset       = 1'b0;
    fq_if.stall = 1'b1;
    #2;
    check_all("t2rst", 0, 1'b0, 8'h00, NOP_INSTR, 3'd0, 8'h00);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      fq_if.stall       = vecs[i].stall;
      fq_if.flush       = vecs[i].flush;
      fq_if.redirect_pc = vecs[i].redir;
      step();
      check_all("vec", i, vecs[i].valid, vecs[i].pc, vecs[i].instr,
                vecs[i].count, vecs[i].addr);
    end
    fq_if.flush       = 1'b0;
    fq_if.redirect_pc = 8'h00;

    // Test 6: build count=3, then asynchronous reset mid-cycle.
    fq_if.stall = 1'b1;
    step();
    check_all("t6", 0, 1'b1, 8'h01, 9'h002, 3'd2, 8'h03);
    step();
    check_all("t6", 1, 1'b1, 8'h01, 9'h002, 3'd3, 8'h04);
    reset = 1'b0;
    #1;
    check_all("t6", 2, 1'b0, 8'h00, NOP_INSTR, 3'd0, 8'h00);
    fq_if.stall       = 1'b0;
    fq_if.flush       = 1'b1;
    fq_if.redirect_pc = 8'h77;
    step();
    check_all("t6", 3, 1'b0, 8'h00, NOP_INSTR, 3'd0, 8'h00);
    fq_if.flush = 1'b0;
    reset       = 1'b1;
    step();
    check_all("t6", 4, 1'b1, 8'h00, 9'h001, 3'd1, 8'h01);
    step();
    check_all("t6", 5, 1'b1, 8'h01, 9'h002, 3'd1, 8'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
